hex_tick_meter: RTL and testbench
=================================

// Module: hex_tick_meter
// PURPOSE
//  Receive-side partner of the hex prescaler/counter: measures the clk-cycle interval between
//  rising edges of an asynchronous tick input and reports each period.
//  Flags periods within tolerance of the expected value, keeps a 4-bit wrapping event count,
//  and detects loss of ticks by timeout. Sits on the consumer side of any tick/prescaler output.
// PARAMETERS
//  CNT_W       26    width of interval counter and period output
//  EXP_PERIOD  30    expected tick period in clk cycles
//  TOL         1     allowed |period - EXP_PERIOD| for in_tol=1
//  TIMEOUT     1000  cycles without a rise before returning to IDLE (2 <= TIMEOUT <= 2^CNT_W-1)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      asynchronous reset, active-high
//  tick_in       in   1      asynchronous tick/level input
//  period        out  CNT_W  last measured interval (clk cycles)
//  period_valid  out  1      1-cycle pulse: period/in_tol just updated
//  in_tol        out  1      last period within EXP_PERIOD +/- TOL
//  ev_hex        out  4      count of detected rising edges, mod 16
//  timeout       out  1      1-cycle pulse: TIMEOUT reached with no rise
//  locked        out  1      1 while state==MEASURE
// BEHAVIOUR
//  - Reset (async, rst=1): all outputs 0, sync flops 0, cnt=0, state=IDLE.
//  - Input path: 2-flop synchronizer s1->s2, plus s3 delay; rise = s2 & ~s3.
//    tick_in first captured high at edge N -> rise true in cycle after N+1 -> outputs update at N+2.
//  - Every rise: ev_hex <= ev_hex+1 (15 wraps to 0), in any state.
//  - FSM IDLE: cnt held 0; rise -> MEASURE, cnt<=1; no period_valid on this first rise.
//  - FSM MEASURE: no rise: cnt<=cnt+1. Rise: period<=cnt, period_valid<=1,
//    in_tol <= (|cnt-EXP_PERIOD| <= TOL), cnt<=1, stay MEASURE.
//    Period equals cycles between consecutive rises (ticks every 30 clk -> period=30).
//  - Timeout: in MEASURE with cnt==TIMEOUT and no rise -> state IDLE, cnt<=0, timeout pulse 1 cycle;
//    period, in_tol hold last values. Rise in same cycle as cnt==TIMEOUT: rise wins (normal measure).
//  - Difference for in_tol computed unsigned-safe at CNT_W+1 bits; no overflow possible since cnt<=TIMEOUT.
//  - period_valid and timeout never both high; each high exactly one cycle per event.
//  - tick_in held high: one rise only, then timeout after TIMEOUT cycles.
//  - Reset mid-measurement: immediate return to reset values; next rise treated as first (IDLE).
// CONFIGURATION
//  HEX_METER_AVG_EN defined: extra output avg_period [CNT_W-1:0] = (sum of last 4 periods)>>2,
//   registered, updated in the same cycle as period_valid; 4-entry history and avg_period
//   cleared to 0 on reset and on timeout (entries fill from 0, so first three averages are partial).
//   Sum held at CNT_W+2 bits.
//  Not defined: avg_period port, history and adder absent; all other behaviour identical.
// TESTING
//  1 reset: rst=1 mid-run -> all outputs 0 same cycle, state IDLE, locked=0.
//  2 tick_in 1-cycle pulse every 30 clk, 6 pulses -> 5 period_valid, period=30, in_tol=1, ev_hex=6.
//  3 ticks every 31 then every 33 clk -> period=31 in_tol=1; period=33 in_tol=0.
//  4 18 ticks -> ev_hex wraps 15->0->1 ends at 2; locked=1 after first tick.
//  5 ticks stop after period 30 -> timeout pulse exactly 1000 clk after last rise, locked=0,
//    period stays 30; next tick gives no period_valid; one after gives valid period.
//  6 HEX_METER_AVG_EN: periods 28,30,32,30 -> avg_period 7,14,22,30 on successive period_valid.

Source files
------------

// File: rtl/hex_tick_meter_if.sv
// Tick-meter signal bundle: the tick input plus the measured results.
// With HEX_METER_AVG_EN defined it also carries the 4-period running average.
interface hex_tick_meter_if #(
   parameter int CNT_W = 26
);
   logic             tick_in;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             in_tol;
   logic [3:0]       ev_hex;
   logic             timeout;
   logic             locked;
`ifdef HEX_METER_AVG_EN
   logic [CNT_W-1:0] avg_period;

   modport master (
      input  tick_in,
      output period, period_valid, in_tol, ev_hex, timeout, locked, avg_period
   );
   modport slave (
      output tick_in,
      input  period, period_valid, in_tol, ev_hex, timeout, locked, avg_period
   );
`else
   modport master (
      input  tick_in,
      output period, period_valid, in_tol, ev_hex, timeout, locked
   );
   modport slave (
      output tick_in,
      input  period, period_valid, in_tol, ev_hex, timeout, locked
   );
`endif
endinterface

// File: rtl/hex_tick_meter.sv
// Measures the clk-cycle spacing of rising edges on an asynchronous tick, flags tolerance,
// counts edges mod 16 and drops lock on timeout. HEX_METER_AVG_EN adds a 4-period average.
module hex_tick_meter #(
   parameter int CNT_W      = 26,
   parameter int EXP_PERIOD = 30,
   parameter int TOL        = 1,
   parameter int TIMEOUT    = 1000
) (
   input  logic             clk,
   input  logic             rst,
   hex_tick_meter_if.master bus
);

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]   EXP_C     = (CNT_W+1)'(EXP_PERIOD);
   localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

   state_t           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic             rise;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             pv_q, pv_d;
   logic             tol_q, tol_d;
   logic [3:0]       ev_q, ev_d;
   logic             to_q, to_d;

   // One extra bit keeps the absolute difference free of wrap-around.
   function automatic logic within_tol(input logic [CNT_W-1:0] c);
      logic [CNT_W:0] a;
      logic [CNT_W:0] d;
      a = {1'b0, c};
      d = (a >= EXP_C) ? (a - EXP_C) : (EXP_C - a);
      return (d <= TOL_C);
   endfunction

`ifdef HEX_METER_AVG_EN
   logic [3:0][CNT_W-1:0] hist_q, hist_d;
   logic [CNT_W-1:0]      avg_q, avg_d;

   function automatic logic [CNT_W-1:0] avg4(input logic [CNT_W-1:0] a, b, c, d);
      logic [CNT_W+1:0] s;
      s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
      return s[CNT_W+1:2];
   endfunction
`endif

   assign rise = s2_q & ~s3_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      tol_d    = tol_q;
      pv_d     = 1'b0;
      to_d     = 1'b0;
      ev_d     = rise ? (ev_q + 4'd1) : ev_q;
`ifdef HEX_METER_AVG_EN
      hist_d   = hist_q;
      avg_d    = avg_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rise) begin
               state_d = MEASURE;
               cnt_d   = CNT_W'(1);
            end
         end
         MEASURE: begin
            // A rise coinciding with cnt==TIMEOUT is still a valid measurement.
            if (rise) begin
               period_d = cnt_q;
               pv_d     = 1'b1;
               tol_d    = within_tol(cnt_q);
               cnt_d    = CNT_W'(1);
`ifdef HEX_METER_AVG_EN
               hist_d   = {hist_q[2:0], cnt_q};
               avg_d    = avg4(cnt_q, hist_q[0], hist_q[1], hist_q[2]);
`endif
            end else if (cnt_q == TIMEOUT_C) begin
               state_d = IDLE;
               cnt_d   = '0;
               to_d    = 1'b1;
`ifdef HEX_METER_AVG_EN
               hist_d  = '0;
               avg_d   = '0;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         cnt_q    <= '0;
         period_q <= '0;
         pv_q     <= 1'b0;
         tol_q    <= 1'b0;
         ev_q     <= 4'd0;
         to_q     <= 1'b0;
`ifdef HEX_METER_AVG_EN
         hist_q   <= '0;
         avg_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         s1_q     <= bus.tick_in;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pv_q     <= pv_d;
         tol_q    <= tol_d;
         ev_q     <= ev_d;
         to_q     <= to_d;
`ifdef HEX_METER_AVG_EN
         hist_q   <= hist_d;
         avg_q    <= avg_d;
`endif
      end
   end

   assign bus.period       = period_q;
   assign bus.period_valid = pv_q;
   assign bus.in_tol       = tol_q;
   assign bus.ev_hex       = ev_q;
   assign bus.timeout      = to_q;
   assign bus.locked       = (state_q == MEASURE);
`ifdef HEX_METER_AVG_EN
   assign bus.avg_period   = avg_q;
`endif

endmodule

// File: tb/tb_hex_tick_meter.sv
// Self-checking bench for hex_tick_meter: directed and randomized tick trains against a
// time-stamp based reference model (rise times, not counters).
module tb_hex_tick_meter;
   localparam int CNT_W = 26;
   localparam int EXP   = 30;
   localparam int TOL   = 1;
   localparam int TMO   = 1000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hex_tick_meter_if #(.CNT_W(CNT_W)) bus ();

   hex_tick_meter #(
      .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .TIMEOUT(TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: time of last detected rise, rise arrivals scheduled two edges after capture.
   longint now;
   bit     have;
   longint last;
   longint m_period;
   bit     m_pv, m_tol, m_to;
   int     m_ev;
   bit     prev_s;
   longint pend[$];
   longint hq[$];
   longint m_avg;

   int     pv_seen, to_seen;
   longint avg_seen[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      now = 0; have = 0; last = 0; m_period = 0;
      m_pv = 0; m_tol = 0; m_to = 0; m_ev = 0; prev_s = 0;
      pend.delete();
      hq = '{0, 0, 0, 0};
      m_avg = 0;
   endtask

   task automatic model_edge(input bit x);
      bit r;
      longint sum;
      now++;
      m_pv = 0; m_to = 0;
      r = (pend.size() > 0) && (pend[0] == now);
      if (r) void'(pend.pop_front());
      if (x && !prev_s) pend.push_back(now + 2);
      prev_s = x;
      if (r) begin
         m_ev = (m_ev + 1) % 16;
         if (have) begin
            m_period = now - last;
            m_pv     = 1;
            m_tol    = ((m_period > EXP) ? (m_period - EXP) : (EXP - m_period)) <= TOL;
            hq.push_back(m_period);
            void'(hq.pop_front());
            sum = 0;
            foreach (hq[i]) sum += hq[i];
            m_avg = sum / 4;
         end
         have = 1;
         last = now;
      end else if (have && (now - last == TMO)) begin
         have  = 0;
         m_to  = 1;
         hq    = '{0, 0, 0, 0};
         m_avg = 0;
      end
   endtask

   task automatic check_all();
      chk("period", bus.period, m_period);
      chk("period_valid", bus.period_valid, m_pv);
      chk("in_tol", bus.in_tol, m_tol);
      chk("ev_hex", bus.ev_hex, m_ev);
      chk("timeout", bus.timeout, m_to);
      chk("locked", bus.locked, have);
`ifdef HEX_METER_AVG_EN
      chk("avg_period", bus.avg_period, m_avg);
`endif
   endtask

   task automatic step(input bit x);
      bus.tick_in = x;
      @(posedge clk);
      model_edge(x);
      #1;
      if (bus.period_valid === 1'b1) pv_seen++;
      if (bus.timeout === 1'b1) to_seen++;
`ifdef HEX_METER_AVG_EN
      if (bus.period_valid === 1'b1) avg_seen.push_back(longint'(bus.avg_period));
`endif
      check_all();
   endtask

   // Tick high for `width` cycles, next pulse starts `gap` cycles after this one.
   task automatic pulse(input int gap, input int width = 1);
      for (int i = 0; i < gap; i++) step(i < width);
   endtask

   task automatic zeros_reset_check();
      chk("rst_period", bus.period, 0);
      chk("rst_valid", bus.period_valid, 0);
      chk("rst_in_tol", bus.in_tol, 0);
      chk("rst_ev_hex", bus.ev_hex, 0);
      chk("rst_timeout", bus.timeout, 0);
      chk("rst_locked", bus.locked, 0);
`ifdef HEX_METER_AVG_EN
      chk("rst_avg", bus.avg_period, 0);
`endif
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1 zeros_reset_check();
      model_reset();
      #2 rst = 1'b0;
   endtask

   initial begin
      int ev0;
      rst = 1'b1;
      bus.tick_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 zeros_reset_check();
      model_reset();
      #2 rst = 1'b0;

      // Nominal 30-cycle ticks
      pv_seen = 0;
      repeat (6) pulse(30);
      chk("t2_valid_count", pv_seen, 5);
      chk("t2_period", bus.period, 30);
      chk("t2_in_tol", bus.in_tol, 1);
      chk("t2_ev_hex", bus.ev_hex, 6);

      // 31 then 33
      step(0);
      pulse(33);
      chk("t3_period31", bus.period, 31);
      chk("t3_tol31", bus.in_tol, 1);
      pulse(33);
      chk("t3_period33", bus.period, 33);
      chk("t3_tol33", bus.in_tol, 0);

      // Mid-measurement reset, then ev_hex wrap with random spacing
      pulse(10);
      do_reset();
      pulse($urandom_range(25, 40));
      chk("t4_locked_first", bus.locked, 1);
      repeat (17) pulse($urandom_range(25, 40));
      chk("t4_ev_wrap", bus.ev_hex, 2);
      chk("t4_locked", bus.locked, 1);

      // Loss of ticks
      pulse(30);
      pulse(30);
      to_seen = 0;
      repeat (1100) step(0);
      chk("t5_timeout_count", to_seen, 1);
      chk("t5_period_hold", bus.period, 30);
      chk("t5_unlocked", bus.locked, 0);
      pv_seen = 0;
      pulse(40);
      chk("t5_first_no_valid", pv_seen, 0);
      pulse(40);
      chk("t5_second_valid", pv_seen, 1);
      chk("t5_period40", bus.period, 40);

      // Gaps around the timeout boundary
      pulse(TMO);
      pulse(TMO + 1);
      pulse(TMO - 1);
      pulse(TMO);
      pulse(30);

      // Held-high input: one rise, then timeout
      ev0 = bus.ev_hex;
      to_seen = 0;
      pulse(1100, 1100);
      chk("held_one_rise", bus.ev_hex, (ev0 + 1) % 16);
      chk("held_timeout", to_seen, 1);

      // Randomized spacing and pulse width
      for (int k = 0; k < 60; k++) begin
         int g;
         g = $urandom_range(2, 70);
         pulse(g, $urandom_range(1, g - 1));
      end
      repeat (TMO + 10) step(0);

`ifdef HEX_METER_AVG_EN
      do_reset();
      avg_seen.delete();
      pulse(28); pulse(30); pulse(32); pulse(30); pulse(10);
      chk("avg_count", avg_seen.size(), 4);
      if (avg_seen.size() == 4) begin
         chk("avg0", avg_seen[0], 7);
         chk("avg1", avg_seen[1], 14);
         chk("avg2", avg_seen[2], 22);
         chk("avg3", avg_seen[3], 30);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
